// File: rtl/ysyx_24110006_lsu.sv
// Load/store unit: takes one instruction per i_valid pulse, runs the AXI4-Lite
// read or write it needs, and hands a single completion pulse to writeback.
module ysyx_24110006_lsu (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic        i_mem_ren,
  input  logic        i_mem_wen,
  input  logic [3:0]  i_mem_wmask,
  input  logic [2:0]  i_mem_read_t,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic [31:0] i_result,
  input  logic [31:0] i_pc,
  input  logic [4:0]  i_reg_rd,
  input  logic        i_reg_wen,
  output logic        o_valid,
  output logic [31:0] o_result,
  output logic [31:0] o_pc,
  output logic [4:0]  o_reg_rd,
  output logic        o_reg_wen,
  output logic        o_busy,
  output logic [1:0]  o_fault,
  output logic [31:0] o_araddr,
  output logic        o_arvalid,
  input  logic        i_arready,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  input  logic        i_rvalid,
  output logic        o_rready,
  output logic [31:0] o_awaddr,
  output logic        o_awvalid,
  input  logic        i_awready,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_wvalid,
  input  logic        i_wready,
  input  logic [1:0]  i_bresp,
  input  logic        i_bvalid,
  output logic        o_bready
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, wdata_reg;
  logic [3:0]  wmask_reg;
  logic [2:0]  read_t_reg;
  logic        aw_done_reg, w_done_reg;
  logic [31:0] result_reg, pc_reg;
  logic [4:0]  rd_reg;
  logic        reg_wen_reg;
  logic [1:0]  fault_reg;

  logic        accept, is_load, is_store, misaligned;
  logic        aw_fire, w_fire;
  logic [31:0] rdata_shift, load_data;

  assign accept   = (state_reg == IDLE) && i_valid;
  // A request with both enables set behaves as a load.
  assign is_load  = i_mem_ren;
  assign is_store = i_mem_wen && !i_mem_ren;

  always_comb begin
    misaligned = 1'b0;
    if (is_load) begin
      case (i_mem_read_t[1:0])
        2'b00:   misaligned = 1'b0;
        2'b01:   misaligned = i_mem_addr[0];
        default: misaligned = |i_mem_addr[1:0];
      endcase
    end else if (is_store) begin
      case (i_mem_wmask)
        4'b0001: misaligned = 1'b0;
        4'b0011: misaligned = i_mem_addr[0];
        default: misaligned = |i_mem_addr[1:0];
      endcase
    end
  end

  assign aw_fire = o_awvalid && i_awready;
  assign w_fire  = o_wvalid && i_wready;

  always_ff @(posedge i_clock) begin
    if (i_reset) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    o_valid    = 1'b0;
    o_busy     = 1'b1;
    o_arvalid  = 1'b0;
    o_rready   = 1'b0;
    o_awvalid  = 1'b0;
    o_wvalid   = 1'b0;
    o_bready   = 1'b0;
    case (state_reg)
      IDLE: begin
        o_busy = 1'b0;
        if (i_valid) begin
          if (misaligned || !(i_mem_ren || i_mem_wen)) state_next = DONE;
          else if (is_load)                            state_next = RADDR;
          else                                         state_next = WREQ;
        end
      end
      RADDR: begin
        o_arvalid = 1'b1;
        if (i_arready) state_next = RDATA;
      end
      RDATA: begin
        o_rready = 1'b1;
        if (i_rvalid) state_next = DONE;
      end
      WREQ: begin
        // Each channel drops its valid independently once accepted.
        o_awvalid = !aw_done_reg;
        o_wvalid  = !w_done_reg;
        if ((aw_done_reg || aw_fire) && (w_done_reg || w_fire)) state_next = WRESP;
      end
      WRESP: begin
        o_bready = 1'b1;
        if (i_bvalid) state_next = DONE;
      end
      DONE: begin
        o_valid    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rdata_shift = i_rdata >> {addr_reg[1:0], 3'b000};

  always_comb begin
    case (read_t_reg)
      3'b000:  load_data = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      3'b001:  load_data = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      3'b100:  load_data = {24'd0, rdata_shift[7:0]};
      3'b101:  load_data = {16'd0, rdata_shift[15:0]};
      default: load_data = rdata_shift;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      addr_reg    <= '0;
      wdata_reg   <= '0;
      wmask_reg   <= '0;
      read_t_reg  <= '0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      result_reg  <= '0;
      pc_reg      <= '0;
      rd_reg      <= '0;
      reg_wen_reg <= 1'b0;
      fault_reg   <= 2'b00;
    end else begin
      if (accept) begin
        addr_reg    <= i_mem_addr;
        wdata_reg   <= i_mem_wdata;
        wmask_reg   <= i_mem_wmask;
        read_t_reg  <= i_mem_read_t;
        aw_done_reg <= 1'b0;
        w_done_reg  <= 1'b0;
        result_reg  <= i_result;
        pc_reg      <= i_pc;
        rd_reg      <= i_reg_rd;
        reg_wen_reg <= i_reg_wen && !is_store && !misaligned;
        fault_reg   <= misaligned ? 2'b01 : 2'b00;
      end
      if (state_reg == WREQ) begin
        if (aw_fire) aw_done_reg <= 1'b1;
        if (w_fire)  w_done_reg  <= 1'b1;
      end
      if (state_reg == RDATA && i_rvalid) begin
        if (i_rresp != 2'b00) begin
          fault_reg   <= 2'b10;
          reg_wen_reg <= 1'b0;
          result_reg  <= '0;
        end else begin
          result_reg  <= load_data;
        end
      end
      if (state_reg == WRESP && i_bvalid && i_bresp != 2'b00) begin
        fault_reg  <= 2'b10;
        result_reg <= '0;
      end
    end
  end

  assign o_result  = result_reg;
  assign o_pc      = pc_reg;
  assign o_reg_rd  = rd_reg;
  assign o_reg_wen = reg_wen_reg;
  assign o_fault   = fault_reg;
  assign o_araddr  = {addr_reg[31:2], 2'b00};
  assign o_awaddr  = {addr_reg[31:2], 2'b00};
  assign o_wstrb   = wmask_reg << addr_reg[1:0];
  assign o_wdata   = wdata_reg << {addr_reg[1:0], 3'b000};

endmodule
